// File: rtl/txn_controller_pkg.sv
// Shared types and sizing for the transaction controller and its per-type tables.
package types_def;
    localparam int ENTRIES = 64;
    localparam int BANKS   = 16;
    localparam int IDX_W   = $clog2(ENTRIES);
    localparam int BANK_W  = $clog2(BANKS);

    typedef enum logic {read, write} r_type;

    typedef struct packed {
        r_type       req_type;
        logic [31:0] address;
        logic [31:0] data;
    } request;

    typedef enum logic [1:0] {ENT_FREE, ENT_PENDING, ENT_ISSUED} ent_state_t;

    function automatic logic [BANK_W-1:0] bank_of(input request r);
        return r.address[BANK_W-1:0];
    endfunction
endpackage

// File: rtl/txn_table.sv
// One request table: entry storage, per-entry state, free-slot finder and
// lowest-index eligible-entry encoder.
//   state       | meaning
//   ENT_FREE    | slot empty, may be allocated
//   ENT_PENDING | accepted, waiting for its bank to be free
//   ENT_ISSUED  | dispatched, waiting for completion
module txn_table
    import types_def::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_en_i,
    input  request           acc_req_i,
    output logic             full_o,
    input  logic [0:BANKS-1] in_busy_i,
    output logic             elig_o,
    output logic [IDX_W-1:0] elig_idx_o,
    output request           elig_req_o,
    input  logic             issue_en_i,
    input  logic             done_en_i,
    input  logic [IDX_W-1:0] done_idx_i,
    output logic             done_hit_o
);
    ent_state_t       state_q [ENTRIES];
    request           entry_q [ENTRIES];
    logic [IDX_W-1:0] free_idx;
    logic             acc_ok;

    // Scanning downward leaves the lowest matching index as the final assignment.
    always_comb begin
        full_o   = 1'b1;
        free_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ENT_FREE) begin
                full_o   = 1'b0;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        elig_o     = 1'b0;
        elig_idx_o = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == ENT_PENDING && !in_busy_i[bank_of(entry_q[i])]) begin
                elig_o     = 1'b1;
                elig_idx_o = IDX_W'(i);
            end
        end
    end

    assign elig_req_o = entry_q[elig_idx_o];
    assign done_hit_o = done_en_i && (state_q[done_idx_i] == ENT_ISSUED);
    assign acc_ok     = acc_en_i && !full_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) state_q[i] <= ENT_FREE;
        end else begin
            if (acc_ok)               state_q[free_idx]   <= ENT_PENDING;
            if (issue_en_i && elig_o) state_q[elig_idx_o] <= ENT_ISSUED;
            if (done_hit_o)           state_q[done_idx_i] <= ENT_FREE;
        end
    end

    // Payload needs no reset; it is only observed while its slot is non-free.
    always_ff @(posedge clk) begin
        if (acc_ok) entry_q[free_idx] <= acc_req_i;
    end
endmodule

// File: rtl/txn_controller.sv
// Front-end transaction controller: read/write tables, round-robin dispatch
// to banks and completion decode back to the host.
module txn_controller
    import types_def::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  request           in_request,
    output logic             out_busy,
    output logic             valid_out,
    output request           out_req,
    output logic [IDX_W-1:0] out_index,
    input  logic [0:BANKS-1] in_busy,
    output logic [0:BANKS-1] bank_out_valid,
    input  logic             request_done_valid,
    input  r_type            the_type,
    input  logic [31:0]      in_data,
    input  logic [IDX_W-1:0] index,
    output logic             wd,
    output logic             rd,
    output logic [31:0]      data
);
    logic             rd_full, wr_full, rd_elig, wr_elig, rd_issue, wr_issue;
    logic             rd_hit, wr_hit;
    logic [IDX_W-1:0] rd_idx, wr_idx;
    request           rd_req, wr_req;

    logic             rr_write_q;
    logic             valid_q, valid_d, rd_q, wd_q;
    request           req_q, req_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [0:BANKS-1] bank_q, bank_d;
    logic [31:0]      data_q;

    txn_table u_rd_tbl (
        .clk, .rst,
        .acc_en_i   (in_valid && in_request.req_type == read),
        .acc_req_i  (in_request),
        .full_o     (rd_full),
        .in_busy_i  (in_busy),
        .elig_o     (rd_elig),
        .elig_idx_o (rd_idx),
        .elig_req_o (rd_req),
        .issue_en_i (rd_issue),
        .done_en_i  (request_done_valid && the_type == read),
        .done_idx_i (index),
        .done_hit_o (rd_hit)
    );

    txn_table u_wr_tbl (
        .clk, .rst,
        .acc_en_i   (in_valid && in_request.req_type == write),
        .acc_req_i  (in_request),
        .full_o     (wr_full),
        .in_busy_i  (in_busy),
        .elig_o     (wr_elig),
        .elig_idx_o (wr_idx),
        .elig_req_o (wr_req),
        .issue_en_i (wr_issue),
        .done_en_i  (request_done_valid && the_type == write),
        .done_idx_i (index),
        .done_hit_o (wr_hit)
    );

    assign out_busy = (in_request.req_type == write) ? wr_full : rd_full;

    // The preference only flips when both tables actually contend.
    always_comb begin
        rd_issue = rd_elig;
        wr_issue = wr_elig;
        if (rd_elig && wr_elig) begin
            rd_issue = !rr_write_q;
            wr_issue = rr_write_q;
        end
        valid_d = rd_issue || wr_issue;
        req_d   = wr_issue ? wr_req : rd_req;
        idx_d   = wr_issue ? wr_idx : rd_idx;
        bank_d  = '0;
        bank_d[bank_of(req_d)] = valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_write_q <= 1'b0;
            valid_q    <= 1'b0;
            req_q      <= '0;
            idx_q      <= '0;
            bank_q     <= '0;
            rd_q       <= 1'b0;
            wd_q       <= 1'b0;
            data_q     <= '0;
        end else begin
            if (rd_elig && wr_elig) rr_write_q <= !rr_write_q;
            valid_q <= valid_d;
            bank_q  <= bank_d;
            if (valid_d) begin
                req_q <= req_d;
                idx_q <= idx_d;
            end
            rd_q <= rd_hit;
            wd_q <= wr_hit;
            if (rd_hit) data_q <= in_data;
        end
    end

    assign valid_out      = valid_q;
    assign out_req        = req_q;
    assign out_index      = idx_q;
    assign bank_out_valid = bank_q;
    assign rd             = rd_q;
    assign wd             = wd_q;
    assign data           = data_q;
endmodule

// File: tb/tb_txn_controller.sv
// Randomized scoreboard bench for txn_controller against a table-level reference model.
module tb_txn_controller;
    import types_def::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    request      in_request = '0;
    logic        out_busy, valid_out;
    request      out_req;
    logic [5:0]  out_index;
    logic [0:15] in_busy = '0;
    logic [0:15] bank_out_valid;
    logic        request_done_valid = 1'b0;
    r_type       the_type = read;
    logic [31:0] in_data = '0;
    logic [5:0]  index = '0;
    logic        wd, rd;
    logic [31:0] data;

    txn_controller dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_request(in_request),
        .out_busy(out_busy), .valid_out(valid_out), .out_req(out_req),
        .out_index(out_index), .in_busy(in_busy), .bank_out_valid(bank_out_valid),
        .request_done_valid(request_done_valid), .the_type(the_type),
        .in_data(in_data), .index(index), .wd(wd), .rd(rd), .data(data)
    );

    always #5 clk = ~clk;

    localparam int M_FREE = 0, M_PEND = 1, M_ISS = 2;
    int     m_st  [2][ENTRIES];
    request m_req [2][ENTRIES];
    bit     m_pref_write;

    typedef struct { int t; int idx; request req; } disp_t;
    typedef struct { int t; logic [31:0] d; } cmp_t;
    disp_t disp_q[$];
    cmp_t  cmp_q[$];

    int n_tests = 0, n_fail = 0;
    logic [0:15] tb_busy = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < ENTRIES; i++) m_st[t][i] = M_FREE;
        m_pref_write = 1'b0;
    endfunction

    function automatic int first_free(input int t);
        for (int i = 0; i < ENTRIES; i++) if (m_st[t][i] == M_FREE) return i;
        return -1;
    endfunction

    function automatic int first_elig(input int t, input logic [0:15] busy);
        for (int i = 0; i < ENTRIES; i++)
            if (m_st[t][i] == M_PEND && !busy[m_req[t][i].address[3:0]]) return i;
        return -1;
    endfunction

    // Drive one cycle of inputs and advance the model across the coming edge.
    task automatic step(input bit s_rst, input bit s_valid, input request s_req,
                        input logic [0:15] s_busy, input bit s_done, input r_type s_type,
                        input logic [5:0] s_idx, input logic [31:0] s_data);
        int  tt, fi, er, ew, win, widx, dt;
        bit  hit;
        @(negedge clk);
        rst = s_rst; in_valid = s_valid; in_request = s_req; in_busy = s_busy;
        request_done_valid = s_done; the_type = s_type; index = s_idx; in_data = s_data;
        #1;
        if (s_rst) begin
            model_reset();
            return;
        end
        tt = int'(s_req.req_type);
        dt = int'(s_type);
        fi = first_free(tt);
        chk("out_busy", out_busy, fi < 0);
        hit = s_done && m_st[dt][s_idx] == M_ISS;
        er = first_elig(0, s_busy);
        ew = first_elig(1, s_busy);
        win = -1;
        if (er >= 0 && ew >= 0) begin
            win = m_pref_write ? 1 : 0;
            m_pref_write = !m_pref_write;
        end else if (er >= 0) win = 0;
        else if (ew >= 0) win = 1;
        if (win >= 0) begin
            widx = (win == 1) ? ew : er;
            disp_q.push_back('{win, widx, m_req[win][widx]});
            m_st[win][widx] = M_ISS;
        end
        if (hit) begin
            m_st[dt][s_idx] = M_FREE;
            cmp_q.push_back('{dt, s_data});
        end
        if (s_valid && fi >= 0) begin
            m_st[tt][fi]  = M_PEND;
            m_req[tt][fi] = s_req;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0, tb_busy, 0, read, '0, '0);
    endtask

    task automatic send(input r_type t, input logic [31:0] a, input logic [31:0] d);
        request r;
        r.req_type = t; r.address = a; r.data = d;
        step(0, 1, r, tb_busy, 0, read, '0, '0);
    endtask

    task automatic done(input r_type t, input logic [5:0] i, input logic [31:0] d);
        step(0, 0, '0, tb_busy, 1, t, i, d);
    endtask

    initial begin : monitor
        disp_t       e;
        cmp_t        c;
        logic [31:0] m_data;
        logic [0:15] oh;
        m_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) m_data = '0;
            chk("valid_out", valid_out, disp_q.size() != 0);
            if (disp_q.size() != 0) begin
                e = disp_q.pop_front();
                if (valid_out) begin
                    chk("out_index", out_index, e.idx);
                    chk("out_req", out_req, e.req);
                    oh = '0;
                    oh[e.req.address[3:0]] = 1'b1;
                    chk("bank_out_valid", bank_out_valid, oh);
                end
            end
            if (!valid_out) chk("bank_out_idle", bank_out_valid, '0);
            chk("rd", rd, cmp_q.size() != 0 && cmp_q[0].t == 0);
            chk("wd", wd, cmp_q.size() != 0 && cmp_q[0].t == 1);
            if (cmp_q.size() != 0) begin
                c = cmp_q.pop_front();
                if (c.t == 0) m_data = c.d;
            end
            chk("data", data, m_data);
        end
    end

    initial begin
        request r;
        int     ct, ci, j;
        bit     dn;
        model_reset();
        repeat (5) step(1, 0, '0, '0, 0, read, '0, '0);
        chk("reset_valid_out", valid_out, 1'b0);
        chk("reset_out_req", out_req, '0);
        chk("reset_out_index", out_index, '0);
        chk("reset_bank", bank_out_valid, '0);
        chk("reset_rd_wd_data", {rd, wd, data}, '0);
        chk("reset_out_busy", out_busy, 1'b0);

        for (int i = 0; i < 64; i++) send(read, 32'h0, 32'd10);
        send(read, 32'h0, 32'd10);
        send(write, 32'h0, 32'd77);
        idle(2);
        done(read, 6'd0, 32'hDEADBEEF);
        send(read, 32'h0, 32'd11);
        idle(2);
        for (int i = 1; i < 4; i++) done(read, 6'(i), 32'h1000 + i);
        tb_busy[0] = 1'b1;
        for (int i = 0; i < 3; i++) send(read, 32'h100, 32'd20 + i);
        idle(4);
        tb_busy[0] = 1'b0;
        idle(4);
        done(write, 6'd0, 32'h0);
        done(write, 6'd5, 32'h5);
        idle(2);

        for (int n = 0; n < 4000; n++) begin
            r.req_type = r_type'($urandom_range(0, 1));
            r.address  = $urandom;
            r.data     = $urandom;
            ct = $urandom_range(0, 1);
            ci = $urandom_range(0, 63);
            dn = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 9) < 8) begin
                for (int k = 0; k < ENTRIES; k++) begin
                    j = (ci + k) % ENTRIES;
                    if (m_st[ct][j] == M_ISS) begin
                        ci = j;
                        break;
                    end
                end
            end
            step(n == 2000 || n == 2001, $urandom_range(0, 99) < 55, r,
                 16'($urandom) & 16'($urandom) & 16'($urandom),
                 dn, r_type'(ct), 6'(ci), $urandom);
        end
        tb_busy = '0;
        idle(10);
        @(posedge clk);
        #2;
        chk("disp_q_drained", disp_q.size(), 0);
        chk("cmp_q_drained", cmp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
